// File: rtl/updown_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// synchronous clear and wrap or saturate behaviour at the count bounds.
module updown_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MODULO   = 256,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             not_rst,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   // The load range check is done one bit wider so MODULO = 2^WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);

   if (WIDTH < 2 || MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_param
      $error("updown_counter: illegal WIDTH/MODULO combination");
   end

   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             err_nxt;
   logic             at_max;
   logic             at_zero;
   logic             d_over;

   assign at_max  = (q == MAX_Q);
   assign at_zero = (q == '0);
   assign d_over  = ({1'b0, d} >= MOD_EXT);
   assign tc      = up ? at_max : at_zero;

   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      err_nxt  = 1'b0;
      if (clr) begin
         q_nxt = '0;
      end else if (load) begin
         if (d_over) begin
            q_nxt   = MAX_Q;
            err_nxt = 1'b1;
         end else begin
            q_nxt = d;
         end
      end else if (en) begin
         if (up) begin
            if (at_max) begin
               wrap_nxt = 1'b1;
               q_nxt    = SATURATE ? q : '0;
            end else begin
               q_nxt = q + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               wrap_nxt = 1'b1;
               q_nxt    = SATURATE ? q : MAX_Q;
            end else begin
               q_nxt = q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge not_rst) begin
      if (!not_rst) begin
         q        <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= q_nxt;
         wrap     <= wrap_nxt;
         load_err <= err_nxt;
      end
   end

endmodule

// File: tb/tb_updown_counter.sv
// Randomised and directed bench for updown_counter: wrap, saturate and
// full-range instances share stimulus; a two-stage cascade is checked separately.
module tb_updown_counter;

   logic       clk = 1'b0;
   logic       not_rst;
   logic       clr, load, en, up;
   logic [3:0] d;

   logic [3:0] q_w, q_s, q_f;
   logic       tc_w, tc_s, tc_f;
   logic       wr_w, wr_s, wr_f;
   logic       le_w, le_s, le_f;

   logic       c_en;
   logic       c_zero = 1'b0;
   logic       c_up   = 1'b1;
   logic [3:0] c_d    = '0;
   logic       en_hi;
   logic [3:0] q_lo, q_hi;
   logic       tc_lo, tc_hi, wr_lo, wr_hi, le_lo, le_hi;

   int errors = 0;
   int checks = 0;

   int mq_w, mq_s, mq_f;
   bit ew_w, ew_s, ew_f;
   bit ee_w, ee_s, ee_f;

   always #5 clk = ~clk;

   updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .not_rst(not_rst), .clr(clr), .load(load), .en(en), .up(up), .d(d),
      .q(q_w), .tc(tc_w), .wrap(wr_w), .load_err(le_w));

   updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_sat (
      .clk(clk), .not_rst(not_rst), .clr(clr), .load(load), .en(en), .up(up), .d(d),
      .q(q_s), .tc(tc_s), .wrap(wr_s), .load_err(le_s));

   updown_counter #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u_full (
      .clk(clk), .not_rst(not_rst), .clr(clr), .load(load), .en(en), .up(up), .d(d),
      .q(q_f), .tc(tc_f), .wrap(wr_f), .load_err(le_f));

   assign en_hi = c_en & tc_lo;

   updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_lo (
      .clk(clk), .not_rst(not_rst), .clr(c_zero), .load(c_zero), .en(c_en), .up(c_up), .d(c_d),
      .q(q_lo), .tc(tc_lo), .wrap(wr_lo), .load_err(le_lo));

   updown_counter #(.WIDTH(4), .MODULO(6), .SATURATE(1'b0)) u_hi (
      .clk(clk), .not_rst(not_rst), .clr(c_zero), .load(c_zero), .en(en_hi), .up(c_up), .d(c_d),
      .q(q_hi), .tc(tc_hi), .wrap(wr_hi), .load_err(le_hi));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference behaviour: value range 0..m-1, modular step unless saturating.
   task automatic model(input int m, input bit sat, inout int q, output bit w, output bit e);
      w = 1'b0;
      e = 1'b0;
      if (clr) begin
         q = 0;
      end else if (load) begin
         if (int'(d) >= m) begin
            q = m - 1;
            e = 1'b1;
         end else begin
            q = int'(d);
         end
      end else if (en) begin
         if (up) begin
            w = (q == m - 1);
            if (!(w && sat)) q = (q + 1) % m;
         end else begin
            w = (q == 0);
            if (!(w && sat)) q = (q + m - 1) % m;
         end
      end
   endtask

   function automatic int exp_tc(input int m, input int q);
      return up ? int'(q == m - 1) : int'(q == 0);
   endfunction

   task automatic check_all(input string tag);
      check({tag, " q_wrap"},  q_w,  mq_w);
      check({tag, " tc_wrap"}, tc_w, exp_tc(10, mq_w));
      check({tag, " wr_wrap"}, wr_w, ew_w);
      check({tag, " le_wrap"}, le_w, ee_w);
      check({tag, " q_sat"},   q_s,  mq_s);
      check({tag, " tc_sat"},  tc_s, exp_tc(10, mq_s));
      check({tag, " wr_sat"},  wr_s, ew_s);
      check({tag, " le_sat"},  le_s, ee_s);
      check({tag, " q_full"},  q_f,  mq_f);
      check({tag, " tc_full"}, tc_f, exp_tc(16, mq_f));
      check({tag, " wr_full"}, wr_f, ew_f);
      check({tag, " le_full"}, le_f, ee_f);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model(10, 1'b0, mq_w, ew_w, ee_w);
      model(10, 1'b1, mq_s, ew_s, ee_s);
      model(16, 1'b0, mq_f, ew_f, ee_f);
      #1;
      check_all(tag);
   endtask

   task automatic model_reset();
      mq_w = 0; mq_s = 0; mq_f = 0;
      ew_w = 0; ew_s = 0; ew_f = 0;
      ee_w = 0; ee_s = 0; ee_f = 0;
   endtask

   task automatic set_in(input logic c, input logic l, input logic e, input logic u, input logic [3:0] dv);
      clr = c; load = l; en = e; up = u; d = dv;
   endtask

   initial begin
      not_rst = 1'b0;
      c_en    = 1'b0;
      set_in(0, 0, 0, 1, 4'd0);
      model_reset();
      #12;
      check_all("reset");
      #1 not_rst = 1'b1;

      // Wrap up from 0: one full lap plus a little.
      set_in(0, 0, 1, 1, 4'd0);
      for (int i = 0; i < 12; i++) step("up");

      // Reset mid-count, asserted and released between edges.
      set_in(1, 0, 0, 1, 4'd0);
      step("clr");
      set_in(0, 0, 1, 1, 4'd0);
      for (int i = 0; i < 6; i++) step("to6");
      #3 not_rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #2 not_rst = 1'b1;
      step("resume1");
      step("resume2");

      // Down from 0 in both modes.
      set_in(1, 0, 0, 0, 4'd0);
      step("clr");
      set_in(0, 0, 1, 0, 4'd0);
      for (int i = 0; i < 12; i++) step("down");

      // Load clamp and priority cases.
      set_in(0, 1, 0, 1, 4'd13);
      step("load13");
      set_in(0, 0, 0, 1, 4'd0);
      step("after_load13");
      set_in(1, 1, 0, 1, 4'd5);
      step("clr_load");
      set_in(0, 1, 1, 1, 4'd3);
      step("load_en");
      set_in(0, 1, 0, 1, 4'd9);
      step("load9");
      set_in(0, 0, 1, 1, 4'd0);
      for (int i = 0; i < 3; i++) step("at_bound");

      // Hold with direction toggling.
      set_in(0, 1, 0, 1, 4'd4);
      step("load4");
      for (int i = 0; i < 5; i++) begin
         set_in(0, 0, 0, i[0], 4'd0);
         step("hold");
      end

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                ($urandom_range(3) != 0), 1'($urandom), 4'($urandom));
         step("rand");
      end

      // Two-stage cascade, 00..59 then roll to 00.
      set_in(0, 0, 0, 1, 4'd0);
      check("casc_start", q_hi * 10 + q_lo, 0);
      c_en = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         step("casc_idle");
         check("casc_count", q_hi * 10 + q_lo, k % 60);
      end
      check("casc_hi_wrap", wr_hi, 1);
      c_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
